// File: rtl/mel_pkg.sv
// mel_pkg: filter-bank tables, FSM encoding and read-path latency shared by mel_filter_ctrl and mel_mac.
// Build option MEL_ROM_OREG_EN selects the 2-cycle registered-output ROM/spectrum read path.
package mel_pkg;

  localparam int NUM_FILT   = 26;
  localparam int FILT_IDX_W = 5;
  localparam int LEN_W      = 8;
  localparam int CNT_W      = 8;

`ifdef MEL_ROM_OREG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // First nonzero bin of each filter; spans overlap like a triangular mel bank.
  localparam logic [8:0] FILT_START [NUM_FILT] = '{
    9'd1,  9'd1,  9'd2,  9'd3,  9'd5,  9'd6,  9'd8,  9'd10, 9'd12, 9'd15,
    9'd17, 9'd20, 9'd23, 9'd27, 9'd30, 9'd34, 9'd38, 9'd43, 9'd47, 9'd52,
    9'd57, 9'd63, 9'd68, 9'd74, 9'd80, 9'd87
  };

  localparam logic [7:0] FILT_LEN [NUM_FILT] = '{
    8'd0,  8'd1,  8'd2,  8'd3,  8'd3,  8'd4,  8'd4,  8'd5,  8'd5,  8'd6,
    8'd6,  8'd7,  8'd7,  8'd8,  8'd8,  8'd9,  8'd9,  8'd10, 8'd10, 8'd11,
    8'd11, 8'd12, 8'd12, 8'd13, 8'd13, 8'd14
  };

  // Weights are packed back to back, so each base is the running sum of FILT_LEN.
  localparam logic [8:0] ROM_BASE [NUM_FILT] = '{
    9'd0,   9'd0,   9'd1,   9'd3,   9'd6,   9'd9,   9'd13,  9'd17,  9'd22,  9'd27,
    9'd33,  9'd39,  9'd46,  9'd53,  9'd61,  9'd69,  9'd78,  9'd87,  9'd97,  9'd107,
    9'd118, 9'd129, 9'd141, 9'd153, 9'd166, 9'd179
  };

endpackage

// File: rtl/mel_mac.sv
// mel_mac: registered weight*power product, clearable accumulator and saturating scaled energy output.
module mel_mac #(
  parameter int W_WIDTH = 8,
  parameter int SPEC_W  = 32,
  parameter int ACC_W   = 48,
  parameter int OUT_W   = 32,
  parameter int WSHIFT  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clr,
  input  logic               i_data_vld,
  input  logic [W_WIDTH-1:0] i_weight,
  input  logic [SPEC_W-1:0]  i_power,
  output logic [OUT_W-1:0]   o_energy
);

  localparam int PROD_W = SPEC_W + W_WIDTH;

  logic [PROD_W-1:0] r_prod;
  logic              r_prod_vld;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_prod     <= PROD_W'(i_weight) * PROD_W'(i_power);
      r_prod_vld <= i_data_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (r_prod_vld) begin
      r_acc <= r_acc + ACC_W'(r_prod);
    end else begin
      r_acc <= r_acc;
    end
  end

  // Anything left above OUT_W after scaling clamps to full scale.
  always_comb begin
    w_shifted = r_acc >> WSHIFT;
    if (|w_shifted[ACC_W-1:OUT_W]) begin
      o_energy = '1;
    end else begin
      o_energy = w_shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/mel_filter_ctrl.sv
// mel_filter_ctrl: per frame, walks each mel filter's bin span and hands off one saturated energy per filter.
// Build option MEL_ROM_OREG_EN: ROM/spectrum reads take 2 cycles, adding one stage to every latency.
module mel_filter_ctrl
  import mel_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int W_WIDTH    = 8,
  parameter int BIN_AW     = 9,
  parameter int SPEC_W     = 32,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 32,
  parameter int WSHIFT     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [W_WIDTH-1:0]    rom_rd_data,
  output logic [BIN_AW-1:0]     spec_addr,
  input  logic [SPEC_W-1:0]     spec_rd_data,
  output logic [OUT_W-1:0]      mel_data,
  output logic [4:0]            mel_idx,
  output logic                  mel_valid,
  input  logic                  mel_ready
);

  state_t                  r_state;
  logic [FILT_IDX_W-1:0]   r_f;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_rom_addr;
  logic [BIN_AW-1:0]       r_spec_addr;
  logic                    r_busy;
  logic                    r_frame_done;
  logic                    r_mel_valid;
  logic [OUT_W-1:0]        r_mel_data;
  logic [4:0]              r_mel_idx;

  logic [LEN_W-1:0]        w_len;
  logic [LEN_W-1:0]        w_enter_len;
  logic [CNT_W-1:0]        w_load_pt;
  logic [FILT_IDX_W-1:0]   w_enter_f;
  logic                    w_last;
  logic                    w_issue;
  logic                    w_start_ok;
  logic                    w_hs;
  logic                    w_enter;
  logic                    w_data_vld;
  logic [OUT_W-1:0]        w_energy;

  always_comb begin
    w_len      = FILT_LEN[r_f];
    w_last     = (r_f == FILT_IDX_W'(NUM_FILT - 1));
    w_issue    = (r_state == ST_RUN) && (r_cnt < w_len);
    // Last accumulate lands RD_LAT+1 cycles after the last issue; capture the cycle after.
    w_load_pt  = CNT_W'(w_len) + CNT_W'(RD_LAT + 1);
    w_start_ok = (r_state == ST_IDLE) && start;
    w_hs       = (r_state == ST_OUT) && r_mel_valid && mel_ready;
    w_enter    = w_start_ok || (w_hs && !w_last);
    if (w_start_ok) begin
      w_enter_f = '0;
    end else if (w_last) begin
      w_enter_f = '0;
    end else begin
      w_enter_f = r_f + FILT_IDX_W'(1);
    end
    w_enter_len = FILT_LEN[w_enter_f];
  end

`ifdef MEL_ROM_OREG_EN
  logic r_vld_d1;
  logic r_vld_d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_d1 <= 1'b0;
      r_vld_d2 <= 1'b0;
    end else begin
      r_vld_d1 <= w_issue;
      r_vld_d2 <= r_vld_d1;
    end
  end

  assign w_data_vld = r_vld_d2;
`else
  logic r_vld_d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_d1 <= 1'b0;
    end else begin
      r_vld_d1 <= w_issue;
    end
  end

  assign w_data_vld = r_vld_d1;
`endif

  mel_mac #(
    .W_WIDTH (W_WIDTH),
    .SPEC_W  (SPEC_W),
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .WSHIFT  (WSHIFT)
  ) u_mac (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_enter),
    .i_data_vld (w_data_vld),
    .i_weight   (rom_rd_data),
    .i_power    (spec_rd_data),
    .o_energy   (w_energy)
  );

  // Frame sequencer: filter index, span counter, address generation and handoff registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_f          <= '0;
      r_cnt        <= '0;
      r_rom_addr   <= '0;
      r_spec_addr  <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_mel_valid  <= 1'b0;
      r_mel_data   <= '0;
      r_mel_idx    <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if ((r_cnt + CNT_W'(1)) >= w_len) begin
            r_state <= ST_DRAIN;
          end else begin
            r_rom_addr  <= r_rom_addr + ADDR_WIDTH'(1);
            r_spec_addr <= r_spec_addr + BIN_AW'(1);
          end
        end
        ST_DRAIN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == w_load_pt) begin
            r_state     <= ST_OUT;
            r_mel_valid <= 1'b1;
            r_mel_data  <= w_energy;
            r_mel_idx   <= 5'(r_f);
          end
        end
        ST_OUT: begin
          if (mel_ready) begin
            r_mel_valid <= 1'b0;
            r_state     <= w_last ? ST_DONE : ST_RUN;
          end
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_frame_done <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
      // A zero-length filter issues nothing, so the address outputs keep their last value.
      if (w_enter) begin
        r_f   <= w_enter_f;
        r_cnt <= '0;
        if (w_enter_len != LEN_W'(0)) begin
          r_rom_addr  <= ADDR_WIDTH'(ROM_BASE[w_enter_f]);
          r_spec_addr <= BIN_AW'(FILT_START[w_enter_f]);
        end
      end
    end
  end

  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign rom_addr   = r_rom_addr;
  assign spec_addr  = r_spec_addr;
  assign mel_data   = r_mel_data;
  assign mel_idx    = r_mel_idx;
  assign mel_valid  = r_mel_valid;

endmodule

// File: tb/tb_mel_filter_ctrl.sv
// Scoreboard bench for mel_filter_ctrl: a reference model fills an expected queue per frame, a monitor checks handoffs.
module tb_mel_filter_ctrl;
  import mel_pkg::*;

`ifdef MEL_ROM_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, start, busy, frame_done, mel_valid, mel_ready;
  logic [8:0]  rom_addr, spec_addr;
  logic [7:0]  rom_rd_data;
  logic [31:0] spec_rd_data, mel_data;
  logic [4:0]  mel_idx;

  always #5 clk = ~clk;

  mel_filter_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .rom_addr(rom_addr), .rom_rd_data(rom_rd_data), .spec_addr(spec_addr),
    .spec_rd_data(spec_rd_data), .mel_data(mel_data), .mel_idx(mel_idx),
    .mel_valid(mel_valid), .mel_ready(mel_ready)
  );

  logic [7:0]  rom_mem  [512];
  logic [31:0] spec_mem [512];
  logic [7:0]  rom_q1, rom_q2;
  logic [31:0] spec_q1, spec_q2;

  always @(posedge clk) begin
    rom_q1  <= rom_mem[rom_addr];
    spec_q1 <= spec_mem[spec_addr];
    rom_q2  <= rom_q1;
    spec_q2 <= spec_q1;
  end
  assign rom_rd_data  = (LAT == 2) ? rom_q2 : rom_q1;
  assign spec_rd_data = (LAT == 2) ? spec_q2 : spec_q1;

  typedef struct { int idx; longint unsigned data; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int cyc = 0, hs_cnt = 0, fd_cnt = 0, prev_hs_cyc = 0;
  bit timing_on = 1'b0;
  int base_m [NUM_FILT];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint unsigned model_energy(int f);
    longint unsigned acc = 0;
    for (int i = 0; i < int'(FILT_LEN[f]); i++)
      acc += longint'(rom_mem[base_m[f] + i]) * longint'(spec_mem[int'(FILT_START[f]) + i]);
    acc = acc >> 8;
    if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
    return acc;
  endfunction

  task automatic fill_mem(input int kind);
    for (int a = 0; a < 512; a++) begin
      case (kind)
        0: begin rom_mem[a] = 8'hFF; spec_mem[a] = 32'd1; end
        1: begin rom_mem[a] = 8'hFF; spec_mem[a] = 32'hFFFF_FFFF; end
        default: begin rom_mem[a] = 8'($urandom); spec_mem[a] = $urandom >> $urandom_range(0, 31); end
      endcase
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks holds during back-pressure.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [4:0]  prev_idx;
  logic [8:0]  prev_rom, prev_spec;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (prev_stall) begin
        check("hold_valid", mel_valid, 1);
        check("hold_data", mel_data, prev_data);
        check("hold_idx", mel_idx, prev_idx);
        check("hold_rom_addr", rom_addr, prev_rom);
        check("hold_spec_addr", spec_addr, prev_spec);
      end
      if (mel_valid && mel_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("mel_idx", mel_idx, e.idx);
          check("mel_data", mel_data, e.data);
          if (timing_on && hs_cnt > 0)
            check("filter_period", cyc - prev_hs_cyc, int'(FILT_LEN[e.idx]) + 3 + LAT);
        end
        prev_hs_cyc = cyc;
        hs_cnt++;
      end
      prev_stall = mel_valid && !mel_ready;
      prev_data  = mel_data;
      prev_idx   = mel_idx;
      prev_rom   = rom_addr;
      prev_spec  = spec_addr;
    end
  end

  // md: 0 plain with timing, 1 stall on filter 3 + stray start, 2 reset on filter 10, 3 random ready
  task automatic run_frame(input int md);
    int n = 0, fd0 = fd_cnt, stall_left = 0;
    bit stall_done = 0, start_done = 0, rst_done = 0, aborted = 0, first_seen = 0;
    for (int f = 0; f < NUM_FILT; f++) exp_q.push_back('{idx: f, data: model_energy(f)});
    hs_cnt = 0;
    timing_on = (md == 0);
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (!aborted && fd_cnt == fd0 && n < 5000) begin
      if (!first_seen && mel_valid) begin
        first_seen = 1;
        check("first_valid_latency", n, int'(FILT_LEN[0]) + 2 + LAT);
      end
      if (md == 1) begin
        if (!stall_done && mel_valid && mel_idx == 5'd3) begin
          mel_ready = 1'b0; stall_left = 20; stall_done = 1;
        end else if (stall_left > 0) begin
          stall_left--;
          if (stall_left == 0) mel_ready = 1'b1;
        end
        if (!start_done && hs_cnt == 5) begin start = 1'b1; start_done = 1; end
        else start = 1'b0;
      end else if (md == 2) begin
        if (rst) begin
          rst = 1'b0; aborted = 1;
          check("rst_busy", busy, 0);
          check("rst_frame_done", frame_done, 0);
          check("rst_rom_addr", rom_addr, 0);
          check("rst_spec_addr", spec_addr, 0);
          check("rst_mel_valid", mel_valid, 0);
          check("rst_mel_data", mel_data, 0);
          check("rst_mel_idx", mel_idx, 0);
        end else if (!rst_done && hs_cnt == 10) begin
          rst = 1'b1; rst_done = 1;
        end
      end else if (md == 3) begin
        mel_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #2;
      n++;
    end
    start = 1'b0;
    mel_ready = 1'b1;
    if (aborted) begin
      exp_q.delete();
      repeat (3) @(posedge clk); #2;
      check("no_frame_done_after_reset", fd_cnt - fd0, 0);
      check("idle_after_reset", busy, 0);
    end else begin
      check("frame_done_seen", fd_cnt - fd0, 1);
      repeat (3) @(posedge clk); #2;
      check("frame_done_once", fd_cnt - fd0, 1);
      check("busy_low_after_frame", busy, 0);
      check("all_filters_out", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int sum = 0;
    for (int f = 0; f < NUM_FILT; f++) begin
      base_m[f] = sum;
      sum += int'(FILT_LEN[f]);
    end
    rst = 1'b1; start = 1'b0; mel_ready = 1'b0;
    fill_mem(0);
    repeat (2) @(posedge clk); #2;
    check("reset_busy", busy, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_rom_addr", rom_addr, 0);
    check("reset_spec_addr", spec_addr, 0);
    check("reset_mel_valid", mel_valid, 0);
    check("reset_mel_data", mel_data, 0);
    check("reset_mel_idx", mel_idx, 0);
    rst = 1'b0; mel_ready = 1'b1;
    repeat (2) @(posedge clk); #2;

    fill_mem(0); run_frame(0);
    fill_mem(1); run_frame(0);
    fill_mem(2); run_frame(1);
    fill_mem(2); run_frame(2);
    fill_mem(2); run_frame(0);
    fill_mem(2); run_frame(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
